// File: rtl/instr_prog_pkg.sv
// Shared types and helpers for the instruction program loader.
package instr_prog_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_READY,
    ST_RUN,
    ST_DONE
  } state_e;

  localparam int          INSTR_W_DEF = 32;
  localparam logic [31:0] NOP_INSTR   = 32'h0000_0000;  // sll r0,r0,0

  // MSB bit position of slot k in the flat image; slot 0 sits at the top.
  function automatic int slot_msb(input int k, input int depth, input int width);
    return depth * width - 1 - k * width;
  endfunction

endpackage

// File: rtl/instr_prog_loader_cycle_timer.sv
// Run-length timer: load latches the terminal value and clears the count,
// enable advances the count, tc_o flags the last cycle of the run.
module cycle_timer #(
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             init,
  input  logic             load_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] term_i,
  output logic [CNT_W-1:0] count_o,
  output logic             tc_o
);

  logic [CNT_W-1:0] term_q;
  logic [CNT_W-1:0] count_q;

  // Terminal value and elapsed count registers.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of its neighbours, regardless of block order.
    if (init) begin
      term_q  <= '0;
      count_q <= '0;
    end else if (load_i) begin
      term_q  <= term_i;
      count_q <= '0;
    end else if (en_i) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  assign count_o = count_q;
  assign tc_o    = en_i && (count_q == term_q - CNT_W'(1));

endmodule

// File: rtl/instr_prog_loader.sv
// Instruction program loader: packs a valid/ready word stream into the flat
// CPU instruction bus, holds the CPU in init while loading, then releases it
// for a programmed number of cycles.
// Build option: define NOP_PAD_EN to zero all other slots on the first beat
// of every new program; otherwise unwritten slots keep their old contents.
module instr_prog_loader
  import instr_prog_pkg::*;
#(
  parameter int DEPTH   = 10,
  parameter int INSTR_W = INSTR_W_DEF,
  parameter int CNT_W   = 16
) (
  input  logic                         clock,
  input  logic                         init,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [INSTR_W-1:0]           in_data,
  input  logic                         in_last,
  input  logic                         start,
  input  logic [CNT_W-1:0]             run_cycles,
  output logic [DEPTH*INSTR_W-1:0]     i_datain,
  output logic                         cpu_init,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic [CNT_W-1:0]             cycle_count,
  output logic                         busy,
  output logic                         done
);

  localparam int            CW      = $clog2(DEPTH + 1);
  localparam int            IMG_W   = DEPTH * INSTR_W;
  localparam int            IDX_W   = $clog2(IMG_W);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  state_e           state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [IMG_W-1:0] image_q, image_d;
  logic             in_ready_q, in_ready_d;
  logic             cpu_init_q, cpu_init_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             accept;
  logic             wr_en;
  logic [IDX_W-1:0] wr_msb;
  logic             timer_load;
  logic             timer_en;
  logic             timer_tc;

  assign accept   = in_valid && in_ready_q;
  assign timer_en = (state_q == ST_RUN);

  cycle_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clock   (clock),
    .init    (init),
    .load_i  (timer_load),
    .en_i    (timer_en),
    .term_i  (run_cycles),
    .count_o (cycle_count),
    .tc_o    (timer_tc)
  );

  // Next-state, image update and registered-output decode.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_d    = state_q;
    count_d    = count_q;
    image_d    = image_q;
    wr_en      = 1'b0;
    wr_msb     = '0;
    timer_load = 1'b0;

    unique case (state_q)
      ST_IDLE, ST_READY, ST_DONE: begin
        if (accept) begin
          // First beat of a new program; a simultaneous start is dropped.
`ifdef NOP_PAD_EN
          for (int k = 0; k < DEPTH; k++) begin
            image_d[IDX_W'(slot_msb(k, DEPTH, INSTR_W)) -: INSTR_W] = INSTR_W'(NOP_INSTR);
          end
`endif
          wr_en   = 1'b1;
          wr_msb  = IDX_W'(slot_msb(0, DEPTH, INSTR_W));
          count_d = CW'(1);
          state_d = (in_last || count_d == DEPTH_C) ? ST_READY : ST_LOAD;
        end else if (start) begin
          timer_load = 1'b1;
          state_d    = (run_cycles == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_LOAD: begin
        if (accept) begin
          wr_en   = 1'b1;
          wr_msb  = IDX_W'(slot_msb(int'(count_q), DEPTH, INSTR_W));
          count_d = count_q + CW'(1);
          if (in_last || count_d == DEPTH_C) state_d = ST_READY;
        end
      end
      ST_RUN: begin
        if (timer_tc) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (wr_en) image_d[wr_msb -: INSTR_W] = in_data;

    in_ready_d = (state_d != ST_RUN) && (count_d < DEPTH_C);
    cpu_init_d = (state_d != ST_RUN);
    busy_d     = (state_d == ST_LOAD) || (state_d == ST_RUN);
    done_d     = (state_d == ST_DONE);
  end

  // State, image and output registers with synchronous reset on init.
  always_ff @(posedge clock) begin
    if (init) begin
      state_q    <= ST_IDLE;
      count_q    <= '0;
      image_q    <= '0;
      in_ready_q <= 1'b1;
      cpu_init_q <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      image_q    <= image_d;
      in_ready_q <= in_ready_d;
      cpu_init_q <= cpu_init_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign in_ready = in_ready_q;
  assign i_datain = image_q;
  assign cpu_init = cpu_init_q;
  assign count    = count_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_instr_prog_loader.sv
// Self-checking bench for instr_prog_loader (default parameters).
module tb_instr_prog_loader;

  localparam int DEPTH = 10;
  localparam int W     = 32;
  localparam int CNT_W = 16;
  localparam int CW    = $clog2(DEPTH + 1);

  logic                 clock;
  logic                 init;
  logic                 in_valid;
  logic                 in_ready;
  logic [W-1:0]         in_data;
  logic                 in_last;
  logic                 start;
  logic [CNT_W-1:0]     run_cycles;
  logic [DEPTH*W-1:0]   i_datain;
  logic                 cpu_init;
  logic [CW-1:0]        count;
  logic [CNT_W-1:0]     cycle_count;
  logic                 busy;
  logic                 done;

  instr_prog_loader #(
    .DEPTH   (DEPTH),
    .INSTR_W (W),
    .CNT_W   (CNT_W)
  ) dut (
    .clock       (clock),
    .init        (init),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_last     (in_last),
    .start       (start),
    .run_cycles  (run_cycles),
    .i_datain    (i_datain),
    .cpu_init    (cpu_init),
    .count       (count),
    .cycle_count (cycle_count),
    .busy        (busy),
    .done        (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    int           slot;
    logic [W-1:0] data;
  } beat_t;

  beat_t        sb_q[$];
  logic [W-1:0] exp_mem [DEPTH];
  int           exp_cnt;
  int           n_checks;
  int           n_pass;

  function automatic logic [W-1:0] dut_slot(input int k);
    return i_datain[DEPTH*W-1-k*W -: W];
  endfunction

  // Model of an accepted beat: first beat restarts the program at slot 0.
  task automatic model_beat(input logic [W-1:0] d, input bit first);
    beat_t b;
    if (first) begin
`ifdef NOP_PAD_EN
      for (int k = 0; k < DEPTH; k++) exp_mem[k] = '0;
`endif
      exp_cnt = 0;
    end
    exp_mem[exp_cnt] = d;
    b.slot = exp_cnt;
    b.data = d;
    sb_q.push_back(b);
    exp_cnt++;
  endtask

  task automatic do_init();
    init     = 1'b1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    start    = 1'b0;
    @(posedge clock); #1;
    @(posedge clock); #1;
    init = 1'b0;
    for (int k = 0; k < DEPTH; k++) exp_mem[k] = '0;
    exp_cnt = 0;
    sb_q.delete();
  endtask

  // Present one word and wait (bounded) for it to be accepted.
  task automatic send(input logic [W-1:0] d, input bit last, input bit first, output bit ok);
    bit rdy;
    ok       = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    for (int t = 0; t < 20; t++) begin
      rdy = in_ready;
      @(posedge clock); #1;
      if (rdy) begin
        ok = 1'b1;
        break;
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (ok) model_beat(d, first);
  endtask

  task automatic test_reset();
    do_init();
    n_checks++; if (cpu_init !== 1'b1) $display("FAIL reset_cpu_init got=%b exp=1", cpu_init); else n_pass++;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b exp=1", in_ready); else n_pass++;
    n_checks++; if (count !== '0) $display("FAIL reset_count got=%0d exp=0", count); else n_pass++;
    n_checks++; if (cycle_count !== '0) $display("FAIL reset_cycle_count got=%0d exp=0", cycle_count); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else n_pass++;
    n_checks++; if (done !== 1'b0) $display("FAIL reset_done got=%b exp=0", done); else n_pass++;
    n_checks++; if (i_datain !== '0) $display("FAIL reset_i_datain got=%h exp=0", i_datain); else n_pass++;
  endtask

  task automatic test_load_run();
    logic [W-1:0] prog [6];
    bit ok;
    int lows;
    int t;
    beat_t b;
    prog = '{32'h2001_0001, 32'h2002_0002, 32'h2003_0003,
             32'h0022_1820, 32'h0061_2022, 32'h0083_2820};
    do_init();
    for (int i = 0; i < 6; i++) begin
      send(prog[i], i == 5, i == 0, ok);
      n_checks++; if (!ok) $display("FAIL load_accept word=%0d got=0 exp=1", i); else n_pass++;
    end
    n_checks++; if (count !== CW'(6)) $display("FAIL load_count got=%0d exp=6", count); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL load_ready_busy got=%b exp=0", busy); else n_pass++;
    while (sb_q.size() > 0) begin
      b = sb_q.pop_front();
      n_checks++;
      if (dut_slot(b.slot) !== b.data) $display("FAIL load_slot%0d got=%h exp=%h", b.slot, dut_slot(b.slot), b.data);
      else n_pass++;
    end
    n_checks++; if (i_datain[319:288] !== 32'h2001_0001) $display("FAIL load_top_bits got=%h exp=20010001", i_datain[319:288]); else n_pass++;

    start = 1'b1; run_cycles = 16'd15;
    @(posedge clock); #1;
    start = 1'b0;
    n_checks++; if (busy !== 1'b1) $display("FAIL run_busy got=%b exp=1", busy); else n_pass++;
    lows = 0; t = 0;
    while (done !== 1'b1 && t < 100) begin
      if (cpu_init === 1'b0) lows++;
      @(posedge clock); #1;
      t++;
    end
    n_checks++; if (t >= 100) $display("FAIL run_timeout got=%0d cycles exp<100", t); else n_pass++;
    n_checks++; if (lows != 15) $display("FAIL run_low_cycles got=%0d exp=15", lows); else n_pass++;
    n_checks++; if (cpu_init !== 1'b1) $display("FAIL run_done_cpu_init got=%b exp=1", cpu_init); else n_pass++;
    n_checks++; if (cycle_count !== 16'd15) $display("FAIL run_cycle_count got=%0d exp=15", cycle_count); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL run_done_busy got=%b exp=0", busy); else n_pass++;
    n_checks++; if (dut_slot(0) !== prog[0]) $display("FAIL run_image_kept got=%h exp=%h", dut_slot(0), prog[0]); else n_pass++;
  endtask

  task automatic test_full();
    bit ok;
    bit held;
    beat_t b;
    do_init();
    for (int i = 0; i < DEPTH; i++) begin
      send(32'h1000_0000 + W'(i), 1'b0, i == 0, ok);
      n_checks++; if (!ok) $display("FAIL full_accept word=%0d got=0 exp=1", i); else n_pass++;
    end
    n_checks++; if (in_ready !== 1'b0) $display("FAIL full_in_ready got=%b exp=0", in_ready); else n_pass++;
    n_checks++; if (count !== CW'(DEPTH)) $display("FAIL full_count got=%0d exp=%0d", count, DEPTH); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL full_ready_busy got=%b exp=0", busy); else n_pass++;
    held = 1'b1;
    for (int i = 0; i < 2; i++) begin
      send(32'hDEAD_0000 + W'(i), 1'b0, 1'b0, ok);
      if (ok) held = 1'b0;
    end
    n_checks++; if (held !== 1'b1) $display("FAIL full_backpressure got=accepted exp=held"); else n_pass++;
    n_checks++; if (count !== CW'(DEPTH)) $display("FAIL full_count_after got=%0d exp=%0d", count, DEPTH); else n_pass++;
    while (sb_q.size() > 0) begin
      b = sb_q.pop_front();
      n_checks++;
      if (dut_slot(b.slot) !== b.data) $display("FAIL full_slot%0d got=%h exp=%h", b.slot, dut_slot(b.slot), b.data);
      else n_pass++;
    end
  endtask

  // Runs from the READY state left by test_full.
  task automatic test_zero_run();
    bit saw_low;
    start = 1'b1; run_cycles = '0;
    @(posedge clock); #1;
    start = 1'b0;
    saw_low = (cpu_init !== 1'b1);
    n_checks++; if (done !== 1'b1) $display("FAIL zero_done got=%b exp=1", done); else n_pass++;
    n_checks++; if (cycle_count !== '0) $display("FAIL zero_cycle_count got=%0d exp=0", cycle_count); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL zero_busy got=%b exp=0", busy); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      @(posedge clock); #1;
      if (cpu_init !== 1'b1) saw_low = 1'b1;
    end
    n_checks++; if (saw_low) $display("FAIL zero_cpu_init got=low exp=high"); else n_pass++;
    n_checks++; if (done !== 1'b1) $display("FAIL zero_done_held got=%b exp=1", done); else n_pass++;
    n_checks++; if (dut_slot(0) !== exp_mem[0]) $display("FAIL zero_image got=%h exp=%h", dut_slot(0), exp_mem[0]); else n_pass++;
  endtask

  task automatic test_init_mid_run();
    bit ok;
    do_init();
    for (int i = 0; i < 3; i++) send(32'h3000_0000 + W'(i), i == 2, i == 0, ok);
    sb_q.delete();
    start = 1'b1; run_cycles = 16'd20;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (5) begin @(posedge clock); #1; end
    n_checks++; if (cpu_init !== 1'b0) $display("FAIL mid_run_cpu_init got=%b exp=0", cpu_init); else n_pass++;
    n_checks++; if (cycle_count !== 16'd5) $display("FAIL mid_run_cycle_count got=%0d exp=5", cycle_count); else n_pass++;
    init = 1'b1;
    @(posedge clock); #1;
    init = 1'b0;
    for (int k = 0; k < DEPTH; k++) exp_mem[k] = '0;
    exp_cnt = 0;
    n_checks++; if (cpu_init !== 1'b1) $display("FAIL init_cpu_init got=%b exp=1", cpu_init); else n_pass++;
    n_checks++; if (i_datain !== '0) $display("FAIL init_i_datain got=%h exp=0", i_datain); else n_pass++;
    n_checks++; if (done !== 1'b0) $display("FAIL init_done got=%b exp=0", done); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL init_busy got=%b exp=0", busy); else n_pass++;
    n_checks++; if (count !== '0) $display("FAIL init_count got=%0d exp=0", count); else n_pass++;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL init_in_ready got=%b exp=1", in_ready); else n_pass++;
    n_checks++; if (cycle_count !== '0) $display("FAIL init_cycle_count got=%0d exp=0", cycle_count); else n_pass++;
  endtask

  task automatic test_start_and_beat();
    bit ok;
    bit rdy;
    bit saw_low;
    beat_t b;
    do_init();
    send(32'h4000_0001, 1'b0, 1'b1, ok);
    send(32'h4000_0002, 1'b1, 1'b0, ok);
    sb_q.delete();
    rdy        = in_ready;
    in_valid   = 1'b1;
    in_data    = 32'h2004_0004;
    in_last    = 1'b0;
    start      = 1'b1;
    run_cycles = 16'd7;
    @(posedge clock); #1;
    in_valid = 1'b0;
    start    = 1'b0;
    if (rdy) model_beat(32'h2004_0004, 1'b1);
    n_checks++; if (rdy !== 1'b1) $display("FAIL sim_ready got=%b exp=1", rdy); else n_pass++;
    n_checks++; if (busy !== 1'b1) $display("FAIL sim_busy_load got=%b exp=1", busy); else n_pass++;
    n_checks++; if (count !== CW'(1)) $display("FAIL sim_count got=%0d exp=1", count); else n_pass++;
    while (sb_q.size() > 0) begin
      b = sb_q.pop_front();
      n_checks++;
      if (dut_slot(b.slot) !== b.data) $display("FAIL sim_slot%0d got=%h exp=%h", b.slot, dut_slot(b.slot), b.data);
      else n_pass++;
    end
    saw_low = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (cpu_init !== 1'b1) saw_low = 1'b1;
      @(posedge clock); #1;
    end
    n_checks++; if (saw_low) $display("FAIL sim_start_dropped got=cpu_init_low exp=high"); else n_pass++;
    n_checks++; if (busy !== 1'b1) $display("FAIL sim_still_load got=%b exp=1", busy); else n_pass++;
  endtask

  task automatic test_back_to_back();
    bit ok;
    beat_t b;
    do_init();
    for (int i = 0; i < 5; i++) send(32'h5000_0000 + W'(i), i == 4, i == 0, ok);
    while (sb_q.size() > 0) begin
      b = sb_q.pop_front();
      n_checks++;
      if (dut_slot(b.slot) !== b.data) $display("FAIL b2b_first_slot%0d got=%h exp=%h", b.slot, dut_slot(b.slot), b.data);
      else n_pass++;
    end
    for (int i = 0; i < 2; i++) send(32'h6000_0000 + W'(i), i == 1, i == 0, ok);
    sb_q.delete();
    n_checks++; if (count !== CW'(2)) $display("FAIL b2b_count got=%0d exp=2", count); else n_pass++;
    for (int k = 0; k < DEPTH; k++) begin
      n_checks++;
      if (dut_slot(k) !== exp_mem[k]) $display("FAIL b2b_slot%0d got=%h exp=%h", k, dut_slot(k), exp_mem[k]);
      else n_pass++;
    end
  endtask

  initial begin
    n_checks   = 0;
    n_pass     = 0;
    init       = 1'b1;
    in_valid   = 1'b0;
    in_data    = '0;
    in_last    = 1'b0;
    start      = 1'b0;
    run_cycles = '0;
    test_reset();
    test_load_run();
    test_full();
    test_zero_run();
    test_init_mid_run();
    test_start_and_beat();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
